emu_io_bridge: RTL

EMU_IO_BRIDGE -- requirements
Module: emu_io_bridge

---
 rtl/emu_io_pkg.sv | 22 ++
 rtl/emu_debounce.sv | 72 +++++++
 rtl/emu_io_bridge.sv | 112 +++++++++++
 3 files changed

// File: rtl/emu_io_pkg.sv
// Shared defaults and GPIO bit positions for the emulation I/O bridge.
package emu_io_pkg;

  localparam int unsigned GPIO_W = 32;

  // Default build-time configuration
  localparam int unsigned DEF_N_SW        = 8;
  localparam int unsigned DEF_N_BTN       = 5;
  localparam int unsigned DEF_N_LED       = 8;
  localparam int unsigned DEF_DB_CYCLES   = 50000;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  // GPIO bit positions: LED_LSB (gpio_out bit driving led 0) and BTN_LSB (gpio_in bit of button 0)
  localparam int unsigned GPIO_LED_LSB = 8;
  localparam int unsigned GPIO_BTN_LSB = 16;

  // Debounce counter width; never below one bit so the type stays legal.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles == 0) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/emu_debounce.sv
// One input channel: multi-flop synchroniser followed by a stability-window debouncer.
// DB_CYCLES = 0 bypasses the filter and no counter is built.
module emu_debounce
  import emu_io_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = DEF_DB_CYCLES,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic stable_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;

  // Synchroniser shift chain; bit 0 samples the raw pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  if (DB_CYCLES == 0) begin : g_bypass
    assign stable_o = synced;
    // Rising edge is visible one stage early so it lines up with the stable update
    assign rise_o   = sync_q[SYNC_STAGES-2] & ~synced;
  end else begin : g_filter
    localparam int unsigned     CntW    = cnt_width(DB_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(DB_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            stable_q, stable_d;
    logic            settle;

    // Count consecutive mismatch cycles; commit on the last one and restart the window
    always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      settle   = 1'b0;
      if (synced != stable_q) begin
        if (cnt_q == CntLast) begin
          settle   = 1'b1;
          stable_d = synced;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    // Counter and debounced value registers
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q    <= '0;
        stable_q <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        stable_q <= stable_d;
      end
    end

    assign stable_o = stable_q;
    assign rise_o   = settle & synced;
  end

endmodule

// File: rtl/emu_io_bridge.sv
// Emulation I/O bridge: debounced switches/buttons into a SoC GPIO input word, registered
// LED drive from the GPIO output word, optional button-press interrupt.
// Optional feature: define EMU_IO_BRIDGE_IRQ_EN to build the pending bits and irq_o.
module emu_io_bridge
  import emu_io_pkg::*;
#(
  parameter int unsigned N_SW        = DEF_N_SW,
  parameter int unsigned N_BTN       = DEF_N_BTN,
  parameter int unsigned N_LED       = DEF_N_LED,
  parameter int unsigned LED_LSB     = GPIO_LED_LSB,
  parameter int unsigned BTN_LSB     = GPIO_BTN_LSB,
  parameter int unsigned DB_CYCLES   = DEF_DB_CYCLES,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_SW-1:0]     sw_i,
  input  logic [N_BTN-1:0]    btn_i,
  input  logic [GPIO_W-1:0]   gpio_out_i,
  input  logic [GPIO_W-1:0]   gpio_ps_i,
  output logic [GPIO_W-1:0]   gpio_in_o,
  output logic [N_LED-1:0]    led_o,
  input  logic [N_BTN-1:0]    irq_clr_i,
  output logic                irq_o
);

  logic [N_SW-1:0]  sw_stable, sw_rise;
  logic [N_BTN-1:0] btn_stable, btn_rise;
  logic [N_LED-1:0] led_q;

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    emu_debounce #(
      .DB_CYCLES   (DB_CYCLES),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_db (
      .clk      (clk),
      .rst_n    (rst_n),
      .pin_i    (sw_i[i]),
      .stable_o (sw_stable[i]),
      .rise_o   (sw_rise[i])
    );
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    emu_debounce #(
      .DB_CYCLES   (DB_CYCLES),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_db (
      .clk      (clk),
      .rst_n    (rst_n),
      .pin_i    (btn_i[i]),
      .stable_o (btn_stable[i]),
      .rise_o   (btn_rise[i])
    );
  end

  // GPIO input word: switches low, buttons at BTN_LSB, PS word above, zero in the gap
  for (genvar i = 0; i < GPIO_W; i++) begin : g_gpio_in
    if (i < N_SW) begin : g_sw_bit
      assign gpio_in_o[i] = sw_stable[i];
    end else if ((i >= BTN_LSB) && (i < BTN_LSB + N_BTN)) begin : g_btn_bit
      assign gpio_in_o[i] = btn_stable[i-BTN_LSB];
    end else if (i >= BTN_LSB + N_BTN) begin : g_ps_bit
      assign gpio_in_o[i] = gpio_ps_i[i];
    end else begin : g_zero_bit
      assign gpio_in_o[i] = 1'b0;
    end
  end

  // LED drive is the selected GPIO output slice delayed one clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q <= '0;
    end else begin
      led_q <= gpio_out_i[LED_LSB +: N_LED];
    end
  end

  assign led_o = led_q;

`ifdef EMU_IO_BRIDGE_IRQ_EN
  logic [N_BTN-1:0] pending_q, pending_d;
  logic             irq_q;

  // A new press wins over a coincident clear on the same bit
  always_comb begin
    pending_d = (pending_q & ~irq_clr_i) | btn_rise;
  end

  // Pending bits and registered interrupt line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      irq_q     <= |pending_q;
    end
  end

  assign irq_o = irq_q;

  logic unused_sigs;
  assign unused_sigs = ^{gpio_out_i, gpio_ps_i, sw_rise};
`else
  assign irq_o = 1'b0;

  logic unused_sigs;
  assign unused_sigs = ^{gpio_out_i, gpio_ps_i, sw_rise, btn_rise, irq_clr_i};
`endif

endmodule
